sm3_block_sched: RTL

- Top-level sequencer for one SM3 hash job.
- Pulls padded 512-bit blocks from the message padding unit one at a time.
- Latches each block into a single-entry buffer and issues it to the compression function (CF) core.
- Tracks first and last block and the block count; signals job completion.
- Sits between the host control interface, the padding unit and the CF core.

---
 rtl/sm3_block_sched.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/sm3_block_sched.sv
// SM3 job sequencer: pulls padded blocks, buffers one, and issues it to the CF core.
// Optional CF watchdog enabled by defining SM3_SCHED_CF_TIMEOUT_EN.
module sm3_block_sched #(
    parameter int BLK_W      = 512,
    parameter int CNT_W      = 16,
    parameter int CF_TIMEOUT = 255
) (
    input  logic             clk_in,
    input  logic             reset_n_in,
    input  logic             sm3_start_in,
    output logic             sm3_en_out,
    output logic             padding_en_out,
    input  logic [BLK_W-1:0] blk_in,
    input  logic             blk_valid_in,
    input  logic             all_done_in,
    output logic [BLK_W-1:0] cf_blk_out,
    output logic             cf_start_out,
    output logic             cf_first_out,
    input  logic             cf_done_in,
    output logic             hash_done_out,
    output logic [CNT_W-1:0] block_cnt_out,
    output logic             err_overrun_out,
    output logic             err_timeout_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_BLK,
        S_ISSUE,
        S_COMPRESS,
        S_DONE
    } state_t;

    state_t state_q, state_d;
    logic   first_flag;
    logic   start_job;
    logic   latch_blk;
    logic   cnt_inc;
    logic   tmo_hit;
    logic   tmo_fire;
    logic   overrun;

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        start_job = 1'b0;
        latch_blk = 1'b0;
        cnt_inc   = 1'b0;
        tmo_fire  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (sm3_start_in) begin
                    start_job = 1'b1;
                    state_d   = S_REQ;
                end
            end
            S_REQ:      state_d = S_WAIT_BLK;
            S_WAIT_BLK: begin
                if (blk_valid_in) begin
                    latch_blk = 1'b1;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE:    state_d = S_COMPRESS;
            S_COMPRESS: begin
                // a done arriving on the watchdog's last cycle takes priority
                if (cf_done_in) begin
                    cnt_inc = 1'b1;
                    state_d = all_done_in ? S_DONE : S_REQ;
                end else if (tmo_hit) begin
                    tmo_fire = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // a block is only welcome while waiting for one; in IDLE it is silently ignored
    assign overrun = blk_valid_in &&
                     (state_q != S_IDLE) && (state_q != S_WAIT_BLK);

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            cf_blk_out      <= '0;
            block_cnt_out   <= '0;
            first_flag      <= 1'b0;
            err_overrun_out <= 1'b0;
        end else begin
            if (latch_blk) begin
                cf_blk_out <= blk_in;
            end
            if (start_job) begin
                block_cnt_out   <= '0;
                first_flag      <= 1'b1;
                err_overrun_out <= 1'b0;
            end else begin
                if (cnt_inc && !(&block_cnt_out)) begin
                    block_cnt_out <= block_cnt_out + 1'b1;
                end
                if (overrun) begin
                    err_overrun_out <= 1'b1;
                end
                if (state_q == S_ISSUE) begin
                    first_flag <= 1'b0;
                end
            end
        end
    end

`ifdef SM3_SCHED_CF_TIMEOUT_EN
    localparam int TW = $clog2(CF_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(CF_TIMEOUT - 1);

    logic [TW-1:0] tmo_cnt;

    assign tmo_hit = (state_q == S_COMPRESS) && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            tmo_cnt         <= '0;
            err_timeout_out <= 1'b0;
        end else begin
            if (state_q == S_ISSUE) begin
                tmo_cnt <= '0;
            end else if (state_q == S_COMPRESS) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (start_job) begin
                err_timeout_out <= 1'b0;
            end else if (tmo_fire) begin
                err_timeout_out <= 1'b1;
            end
        end
    end
`else
    assign tmo_hit         = 1'b0;
    assign err_timeout_out = 1'b0;
`endif

    assign sm3_en_out     = (state_q != S_IDLE);
    assign padding_en_out = (state_q == S_REQ);
    assign cf_start_out   = (state_q == S_ISSUE);
    assign cf_first_out   = (state_q == S_ISSUE) && first_flag;
    assign hash_done_out  = (state_q == S_DONE);

endmodule
